// File: rtl/instruction_fetch_unit_if.sv
// Fetch unit bus bundle: instruction-memory request/response and decode handshake.
// master = fetch unit side, slave = memory/decode side.
interface instruction_fetch_unit_if;
  logic [31:0] Address;
  logic        MemReq;
  logic [31:0] Instruction;
  logic        MemAck;
  logic        IfValid;
  logic        IfReady;
  logic [31:0] IfInstr;
  logic [31:0] IfPC;
  logic [31:0] IfPCPlus4;

  modport master (
    output Address, MemReq,
    input  Instruction, MemAck,
    output IfValid, IfInstr, IfPC, IfPCPlus4,
    input  IfReady
  );

  modport slave (
    input  Address, MemReq,
    output Instruction, MemAck,
    input  IfValid, IfInstr, IfPC, IfPCPlus4,
    output IfReady
  );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch: owns PC, one outstanding memory request, 2-entry {PC,instr} buffer.
// IFU_ALIGN_CHECK_EN: misaligned redirect raises sticky Fault and halts fetch.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic                      Clk,
  input  logic                      Reset_n,
  instruction_fetch_unit_if.master  bus,
  input  logic                      Redirect,
  input  logic [31:0]               RedirectPC,
  output logic                      Fault
);

  localparam logic [1:0] DEPTH = 2'(BUF_DEPTH);

  typedef enum logic [1:0] {
    S_FETCH,
    S_DISCARD,
    S_HALT
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_run;
  logic [31:0] r_pc;
  logic [31:0] r_old_addr;
  logic [1:0]  r_count;
  logic        r_rd;
  logic [31:0] r_ent_pc  [2];
  logic [31:0] r_ent_ins [2];

  logic        w_req;
  logic        w_ack;
  logic        w_push;
  logic        w_pop;
  logic        w_flush;
  logic        w_bad;
  logic        w_wp;
  logic [31:0] w_rpc;
  logic [31:0] w_pc_nxt;
  logic [31:0] w_old_nxt;

`ifdef IFU_ALIGN_CHECK_EN
  assign w_rpc = RedirectPC;
  assign w_bad = Redirect && (RedirectPC[1:0] != 2'b00);
  assign Fault = (r_state == S_HALT);
`else
  assign w_rpc = RedirectPC & ~32'h3;
  assign w_bad = 1'b0;
  assign Fault = 1'b0;
`endif

  // Request is a function of registered state only; held until acked.
  assign w_req = r_run
               && ((r_state == S_FETCH && r_count < DEPTH)
                || r_state == S_DISCARD);
  assign w_ack = w_req && bus.MemAck;
  assign w_pop = bus.IfValid && bus.IfReady && !w_flush;
  assign w_wp  = r_rd ^ r_count[0];

  assign bus.MemReq    = w_req;
  assign bus.Address   = (r_state == S_DISCARD) ? r_old_addr : r_pc;
  assign bus.IfValid   = (r_count != 2'd0);
  assign bus.IfPC      = r_ent_pc[r_rd];
  assign bus.IfInstr   = r_ent_ins[r_rd];
  assign bus.IfPCPlus4 = r_ent_pc[r_rd] + 32'd4;

  // Next state, PC and buffer push/flush decisions.
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_old_nxt   = r_old_addr;
    w_push      = 1'b0;
    w_flush     = 1'b0;
    unique case (r_state)
      S_FETCH: begin
        if (w_bad) begin
          w_flush     = 1'b1;
          w_state_nxt = S_HALT;
        end else if (Redirect) begin
          w_flush  = 1'b1;
          w_pc_nxt = w_rpc;
          if (w_req && !bus.MemAck) begin
            w_old_nxt   = r_pc;
            w_state_nxt = S_DISCARD;
          end
        end else if (w_ack) begin
          w_push   = 1'b1;
          w_pc_nxt = r_pc + 32'd4;
        end
      end
      S_DISCARD: begin
        if (w_bad) begin
          w_flush     = 1'b1;
          w_state_nxt = S_HALT;
        end else begin
          if (Redirect) begin
            w_flush  = 1'b1;
            w_pc_nxt = w_rpc;
          end
          if (w_ack) w_state_nxt = S_FETCH;
        end
      end
      default: begin
      end
    endcase
  end

  // State, PC and buffer registers.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      r_state    <= S_FETCH;
      r_run      <= 1'b0;
      r_pc       <= RESET_PC;
      r_old_addr <= RESET_PC;
      r_count    <= 2'd0;
      r_rd       <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        r_ent_pc[i]  <= '0;
        r_ent_ins[i] <= '0;
      end
    end else begin
      r_state    <= w_state_nxt;
      r_run      <= 1'b1;
      r_pc       <= w_pc_nxt;
      r_old_addr <= w_old_nxt;
      if (w_flush)
        r_count <= 2'd0;
      else if (w_push && !w_pop)
        r_count <= r_count + 2'd1;
      else if (!w_push && w_pop)
        r_count <= r_count - 2'd1;
      if (w_pop) r_rd <= ~r_rd;
      if (w_push) begin
        r_ent_pc[w_wp]  <= r_pc;
        r_ent_ins[w_wp] <= bus.Instruction;
      end
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Testbench for instruction_fetch_unit: queue-level reference model,
// directed scenarios with literal expectations, then randomized traffic.
module tb_instruction_fetch_unit;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ins;
  } ent_t;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic        Redirect;
  logic [31:0] RedirectPC;
  logic        Fault;

  instruction_fetch_unit_if bus ();

  instruction_fetch_unit #(
    .RESET_PC  (32'h0000_0000),
    .BUF_DEPTH (2)
  ) dut (
    .Clk        (Clk),
    .Reset_n    (Reset_n),
    .bus        (bus.master),
    .Redirect   (Redirect),
    .RedirectPC (RedirectPC),
    .Fault      (Fault)
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int failures = 0;

  ent_t        q[$];
  logic [31:0] pops[$];
  logic [31:0] m_pc = 0;
  logic [31:0] m_old = 0;
  logic        m_disc = 0;
  logic        m_run = 0;
  logic        m_halt = 0;
  logic        m_live = 0;
  int          acks = 0;

  int mem_delay = 0;
  int ack_force = -1;
  int busy = 0;
  int waitc = 0;

  function automatic logic [31:0] memv(input logic [31:0] a);
    if (a == 32'h0) return 32'h3408_0032;
    if (a == 32'h4) return 32'hac08_0000;
    return {a[15:0], a[31:16]} ^ 32'hA5C3_0F1E;
  endfunction

  task automatic chk(input string n, input logic [31:0] a,
                     input logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", n, a, e);
    end
  endtask

  task automatic chk1(input string n, input logic a, input logic e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s actual=%b required=%b", n, a, e);
    end
  endtask

  // One clock: compare at negedge, play memory, drive, advance model.
  task automatic step();
    logic exp_req;
    logic [31:0] exp_addr;
    logic ack;
    logic pop;
    @(negedge Clk);
    exp_req  = m_run && !m_halt && (m_disc || q.size() < 2);
    exp_addr = m_disc ? m_old : m_pc;
    if (m_live) begin
      chk1("memreq", bus.MemReq, exp_req);
      chk("address", bus.Address, exp_addr);
      chk1("ifvalid", bus.IfValid, q.size() != 0);
      if (q.size() != 0) begin
        chk("ifpc", bus.IfPC, q[0].pc);
        chk("ifinstr", bus.IfInstr, q[0].ins);
        chk("ifpc4", bus.IfPCPlus4, q[0].pc + 32'd4);
      end
      chk1("fault", Fault, m_halt);
    end
    if (bus.MemReq === 1'b1) begin
      if (busy == 0) begin
        busy  = 1;
        waitc = (mem_delay < 0) ? $urandom_range(0, 3) : mem_delay;
      end
      bus.MemAck = (waitc == 0);
      if (waitc == 0) busy = 0;
      else waitc--;
    end else begin
      bus.MemAck = 1'b0;
      busy = 0;
    end
    if (ack_force >= 0) bus.MemAck = (ack_force != 0);
    bus.Instruction = memv(bus.Address);
    if (!Reset_n) begin
      q.delete();
      m_pc = 0; m_old = 0; m_disc = 0;
      m_run = 0; m_halt = 0; m_live = 1;
    end else if (!m_halt) begin
      ack = exp_req && bus.MemAck;
      pop = (q.size() != 0) && bus.IfReady && !Redirect;
      if (pop) begin
        pops.push_back(q[0].pc);
        void'(q.pop_front());
      end
      if (Redirect) begin
        q.delete();
`ifdef IFU_ALIGN_CHECK_EN
        if (RedirectPC[1:0] != 2'b00) m_halt = 1;
        else
`endif
        begin
          if (m_disc) begin
            if (ack) m_disc = 0;
          end else if (exp_req && !ack) begin
            m_old  = m_pc;
            m_disc = 1;
          end
          m_pc = RedirectPC & ~32'h3;
        end
      end else if (ack) begin
        if (m_disc) m_disc = 0;
        else begin
          q.push_back('{m_pc, memv(m_pc)});
          m_pc = m_pc + 32'd4;
        end
      end
      if (ack) acks++;
      m_run = 1;
    end
    @(posedge Clk);
    #1;
  endtask

  initial begin
    int n;
    Reset_n = 0; Redirect = 0; RedirectPC = 0;
    bus.IfReady = 0; bus.MemAck = 0; bus.Instruction = 0;

    // reset state
    repeat (3) step();
    chk1("rst_memreq", bus.MemReq, 1'b0);
    chk("rst_addr", bus.Address, 32'h0);
    chk1("rst_valid", bus.IfValid, 1'b0);
    chk("rst_instr", bus.IfInstr, 32'h0);
    chk("rst_pc", bus.IfPC, 32'h0);
    chk("rst_pc4", bus.IfPCPlus4, 32'h4);
    chk1("rst_fault", Fault, 1'b0);

    // release and stream with combinational memory
    Reset_n = 1; mem_delay = 0; bus.IfReady = 1;
    step();
    chk1("t1_req_after_rst", bus.MemReq, 1'b1);
    chk1("t2_not_yet_valid", bus.IfValid, 1'b0);
    step();
    chk1("t2_valid0", bus.IfValid, 1'b1);
    chk("t2_pc0", bus.IfPC, 32'h0);
    chk("t2_ins0", bus.IfInstr, 32'h3408_0032);
    step();
    chk("t2_pc1", bus.IfPC, 32'h4);
    chk("t2_ins1", bus.IfInstr, 32'hac08_0000);

    // backpressure, with a late ack arriving right after reset
    Reset_n = 0; step(); step();
    Reset_n = 1; bus.IfReady = 0; acks = 0;
    ack_force = 1; step(); ack_force = -1;
    repeat (5) step();
    chk("t3_acks", 32'(acks), 32'd2);
    chk1("t3_req_off", bus.MemReq, 1'b0);
    chk("t3_addr_hold", bus.Address, 32'h8);
    pops.delete();
    bus.IfReady = 1;
    repeat (4) step();
    chk1("t3_npops", pops.size() >= 3, 1'b1);
    if (pops.size() >= 3) begin
      chk("t3_pop0", pops[0], 32'h0);
      chk("t3_pop1", pops[1], 32'h4);
      chk("t3_pop2", pops[2], 32'h8);
    end

    // redirect while a slow request is outstanding
    Reset_n = 0; step();
    Reset_n = 1; mem_delay = 3; step();
    step();
    chk1("t4_pending", bus.MemReq, 1'b1);
    Redirect = 1; RedirectPC = 32'h2C; step(); Redirect = 0;
    chk("t4_old_addr", bus.Address, 32'h0);
    chk1("t4_req_held", bus.MemReq, 1'b1);
    chk1("t4_flushed", bus.IfValid, 1'b0);
    mem_delay = 0;
    n = 0;
    while (bus.Address !== 32'h2C && n < 10) begin step(); n++; end
    chk("t4_new_addr", bus.Address, 32'h2C);
    n = 0;
    while (bus.IfValid !== 1'b1 && n < 10) begin step(); n++; end
    chk1("t4_valid", bus.IfValid, 1'b1);
    chk("t4_first_pc", bus.IfPC, 32'h2C);

    // redirect coinciding with an ack and a decode pop
    bus.IfReady = 0; step(); step();
    bus.IfReady = 1; step();
    chk1("t5_req_pre", bus.MemReq, 1'b1);
    chk1("t5_valid_pre", bus.IfValid, 1'b1);
    Redirect = 1; RedirectPC = 32'h40; step(); Redirect = 0;
    chk1("t5_flushed", bus.IfValid, 1'b0);
    chk("t5_addr", bus.Address, 32'h40);
    step();
    chk1("t5_valid", bus.IfValid, 1'b1);
    chk("t5_pc", bus.IfPC, 32'h40);

    // misaligned redirect
    Redirect = 1; RedirectPC = 32'h46; step(); Redirect = 0;
`ifdef IFU_ALIGN_CHECK_EN
    chk1("t6_fault", Fault, 1'b1);
    chk1("t6_req_off", bus.MemReq, 1'b0);
    repeat (5) step();
    chk1("t6_fault_sticky", Fault, 1'b1);
    chk1("t6_req_still_off", bus.MemReq, 1'b0);
    chk1("t6_valid_off", bus.IfValid, 1'b0);
    Reset_n = 0; step(); Reset_n = 1;
    chk1("t6_fault_cleared", Fault, 1'b0);
`else
    chk("t6_addr", bus.Address, 32'h44);
    chk1("t6_no_fault", Fault, 1'b0);
    step();
    chk1("t6_valid", bus.IfValid, 1'b1);
    chk("t6_pc", bus.IfPC, 32'h44);
`endif

    // randomized traffic
    mem_delay = -1;
    for (int i = 0; i < 3000; i++) begin
      bus.IfReady = ($urandom_range(0, 3) != 0);
      Redirect    = ($urandom_range(0, 19) == 0);
`ifdef IFU_ALIGN_CHECK_EN
      RedirectPC  = $urandom & 32'h0000_FFFC;
`else
      RedirectPC  = $urandom & 32'h0000_FFFF;
`endif
      Reset_n     = ($urandom_range(0, 299) != 0);
      step();
    end
    Redirect = 0; Reset_n = 1;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
